bbc_keyboard: RTL and testbench
===============================

// Module: bbc_keyboard
// PURPOSE
//  PS/2-to-BBC keyboard matrix emulator; downstream/peripheral of system VIA port A + CA2.
//  Decodes PS/2 scancodes into a 10x8 key matrix, answers VIA column/row probes on PA7,
//  runs the 1 MHz autoscan counter that raises the CA2 keyboard interrupt, exports BREAK.
// PARAMETERS
//  DIP_LINKS  8'h00   startup links; bit n read as row 0, column n+2 (1 = link made = pressed)
//  TIMEOUT    16'd6000 clk cycles without PS/2 falling edge before a partial frame is aborted
// PORTS
//  clk         in   1  system clock
//  nRESET      in   1  synchronous, active-low reset
//  clk_en      in   1  1 MHz strobe; advances autoscan counter
//  ps2_clk     in   1  raw PS/2 clock (async)
//  ps2_data    in   1  raw PS/2 data (async)
//  nKBEN       in   1  0 = CPU probe mode (column from col_sel), 1 = autoscan
//  col_sel     in   4  probed column (VIA PA[3:0])
//  row_sel     in   3  probed row (VIA PA[6:4])
//  key_pressed out  1  state of matrix[row_sel][active column] (to VIA PA7)
//  kb_irq      out  1  any key rows 1..7 of active column pressed (to VIA CA2)
//  break_key   out  1  level: BREAK (PS/2 F12) currently held
// BEHAVIOUR
//  Reset: matrix, flags, shifter, scan_col=0, key_pressed=0, kb_irq=0, break_key=0; any
//   partial PS/2 frame abandoned. Reset mid-frame -> next bits ignored until line idle edge.
//  Sync: ps2_clk/ps2_data through 2 flops; ps2_clk also 4-sample glitch filter; act on filtered
//   falling edge only.
//  RX FSM: IDLE -(edge, data=0)-> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE.
//   IDLE edge with data=1: stay IDLE. Odd parity; stop must be 1. Any failure: drop byte.
//   Timeout counter reset on every edge; reaching TIMEOUT in non-IDLE state -> IDLE, drop.
//   Good byte: 1-cycle byte_valid pulse one clk after stop-bit edge.
//  Decoder (per byte_valid): E0 -> ext=1; F0 -> rel=1; else lookup {ext,code} -> {hit,row,col};
//   hit: matrix[row][col] <= ~rel; code 07 (F12): break_key <= ~rel; then ext=rel=0.
//   Unmapped code (incl. E1 sequence bytes): clear ext/rel, matrix unchanged.
//   Repeated make of held key: no change. Release of unpressed key: no change.
//  Active column: nKBEN=0 -> col_sel; nKBEN=1 -> scan_col.
//  scan_col: on clk_en & nKBEN=1, +1 mod 16 (15->0). While nKBEN=0 loaded from col_sel each clk,
//   so autoscan resumes from last probed column.
//  Read: columns 10..15 read all-zero. Row 0 cols 2..9 read DIP_LINKS[col-2] (not PS/2 keys);
//   row 0 cols 0,1 are SHIFT/CTRL from matrix.
//  Outputs registered: key_pressed, kb_irq valid 1 clk after inputs/matrix change. Matrix write
//   and read in same cycle: read returns pre-write value; new value next cycle.
//  kb_irq = |matrix[7:1][active col]; DIP links never assert kb_irq.
// STRUCTURE
//  TOP.vh: KB_COLS=10, KB_ROWS=8, PS/2 byte constants (E0,F0,F12=07), RX state encodings.
//  Sub-module ps2_bbc_map: combinational ROM {ext,code[7:0]} -> {hit,row[2:0],col[3:0]}.
//  Top holds RX FSM, decoder flags, 80-bit matrix, scan counter, output registers.
// TESTING
//  Frame 0x1C (A), nKBEN=0, col_sel=1, row_sel=4 -> key_pressed=1 within 2 clk of stop bit;
//   then F0,1C -> key_pressed=0.
//  Frame 0x1C with parity bit inverted -> matrix unchanged, key_pressed stays 0; next good 1C
//   accepted.
//  A held, nKBEN=1, 32 clk_en strobes -> kb_irq high only when scan_col==1, period 16 strobes;
//   SHIFT (12) held alone -> kb_irq never high (row 0).
//  DIP_LINKS=8'hA5, nKBEN=0, row_sel=0, col_sel=2..9 -> key_pressed=1,0,1,0,0,1,0,1;
//   col_sel=12 with any key -> 0.
//  F12 make -> break_key=1; F0,07 -> 0; matrix untouched. E0,75 (cursor up) sets its cell,
//   plain 75 does not.
//  5 bits of a frame then stall TIMEOUT+10 clk, then full 0x1C -> A decoded correctly; nRESET
//   pulsed mid-frame -> all outputs 0, next full frame decoded.

Source files
------------

// File: rtl/bbc_keyboard_pkg.sv
// rtl/bbc_keyboard_pkg.sv - shared constants and types for the PS/2-to-BBC keyboard matrix
package bbc_keyboard_pkg;

    localparam int KB_COLS = 10;
    localparam int KB_ROWS = 8;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_REL = 8'hF0;
    localparam logic [7:0] PS2_F12 = 8'h07;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] row;
        logic [3:0] col;
    } key_loc_t;

    // Argument is the BBC internal key number (&RC: row in the high nibble, column low)
    function automatic key_loc_t key_at(input logic [6:0] num);
        return {1'b1, num[6:4], num[3:0]};
    endfunction

endpackage

// File: rtl/bbc_keyboard_ps2_bbc_map.sv
// rtl/bbc_keyboard_ps2_bbc_map.sv - combinational ROM from {ext, set-2 scancode} to BBC matrix cell
module bbc_keyboard_ps2_bbc_map
    import bbc_keyboard_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output key_loc_t   loc
);

    always_comb begin
        loc = '0;
        case ({ext, code})
            9'h012, 9'h059: loc = key_at(7'h00);
            9'h014, 9'h114: loc = key_at(7'h01);
            9'h015: loc = key_at(7'h10);
            9'h026: loc = key_at(7'h11);
            9'h025: loc = key_at(7'h12);
            9'h02E: loc = key_at(7'h13);
            9'h00C: loc = key_at(7'h14);
            9'h03E: loc = key_at(7'h15);
            9'h083: loc = key_at(7'h16);
            9'h04E: loc = key_at(7'h17);
            9'h055: loc = key_at(7'h18);
            9'h16B: loc = key_at(7'h19);
            9'h009: loc = key_at(7'h20);
            9'h01D: loc = key_at(7'h21);
            9'h024: loc = key_at(7'h22);
            9'h02C: loc = key_at(7'h23);
            9'h03D: loc = key_at(7'h24);
            9'h043: loc = key_at(7'h25);
            9'h046: loc = key_at(7'h26);
            9'h045: loc = key_at(7'h27);
            9'h00E: loc = key_at(7'h28);
            9'h172: loc = key_at(7'h29);
            9'h016: loc = key_at(7'h30);
            9'h01E: loc = key_at(7'h31);
            9'h023: loc = key_at(7'h32);
            9'h02D: loc = key_at(7'h33);
            9'h036: loc = key_at(7'h34);
            9'h03C: loc = key_at(7'h35);
            9'h044: loc = key_at(7'h36);
            9'h04D: loc = key_at(7'h37);
            9'h054: loc = key_at(7'h38);
            9'h175: loc = key_at(7'h39);
            9'h058: loc = key_at(7'h40);
            9'h01C: loc = key_at(7'h41);
            9'h022: loc = key_at(7'h42);
            9'h02B: loc = key_at(7'h43);
            9'h035: loc = key_at(7'h44);
            9'h03B: loc = key_at(7'h45);
            9'h042: loc = key_at(7'h46);
            9'h052: loc = key_at(7'h47);
            9'h05A: loc = key_at(7'h49);
            9'h01B: loc = key_at(7'h51);
            9'h021: loc = key_at(7'h52);
            9'h034: loc = key_at(7'h53);
            9'h033: loc = key_at(7'h54);
            9'h031: loc = key_at(7'h55);
            9'h04B: loc = key_at(7'h56);
            9'h04C: loc = key_at(7'h57);
            9'h05B: loc = key_at(7'h58);
            9'h066: loc = key_at(7'h59);
            9'h00D: loc = key_at(7'h60);
            9'h01A: loc = key_at(7'h61);
            9'h029: loc = key_at(7'h62);
            9'h02A: loc = key_at(7'h63);
            9'h032: loc = key_at(7'h64);
            9'h03A: loc = key_at(7'h65);
            9'h041: loc = key_at(7'h66);
            9'h049: loc = key_at(7'h67);
            9'h04A: loc = key_at(7'h68);
            9'h169: loc = key_at(7'h69);
            9'h076: loc = key_at(7'h70);
            9'h005: loc = key_at(7'h71);
            9'h006: loc = key_at(7'h72);
            9'h004: loc = key_at(7'h73);
            9'h003: loc = key_at(7'h74);
            9'h00B: loc = key_at(7'h75);
            9'h00A: loc = key_at(7'h76);
            9'h001: loc = key_at(7'h77);
            9'h05D: loc = key_at(7'h78);
            9'h174: loc = key_at(7'h79);
            default: loc = '0;
        endcase
    end

endmodule

// File: rtl/bbc_keyboard.sv
// rtl/bbc_keyboard.sv - PS/2 receiver, BBC key matrix, VIA probe/autoscan and BREAK output
module bbc_keyboard
    import bbc_keyboard_pkg::*;
#(
    parameter logic [7:0]  DIP_LINKS = 8'h00,
    parameter logic [15:0] TIMEOUT   = 16'd6000
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nKBEN,
    input  logic [3:0] col_sel,
    input  logic [2:0] row_sel,
    output logic       key_pressed,
    output logic       kb_irq,
    output logic       break_key
);

    logic [1:0]  clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic [3:0]  clk_hist_q, clk_hist_d;
    logic        clk_filt_q, clk_filt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        resync_q, resync_d;
    rx_state_t   state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_ok_q, parity_ok_d;
    logic        byte_valid_q, byte_valid_d;
    logic        ext_q, ext_d, rel_q, rel_d;
    logic [KB_ROWS-1:0][KB_COLS-1:0] matrix_q, matrix_d;
    logic        break_q, break_d;
    logic [3:0]  scan_col_q, scan_col_d;
    logic        key_pressed_q, key_pressed_d, kb_irq_q, kb_irq_d;

    logic        fall, ps2_bit, timed_out;
    logic [3:0]  active_col;
    logic [2:0]  dip_off;
    key_loc_t    map_loc;

    bbc_keyboard_ps2_bbc_map u_map (
        .ext  (ext_q),
        .code (shift_q),
        .loc  (map_loc)
    );

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        clk_hist_d  = {clk_hist_q[2:0], clk_sync_q[1]};
        clk_filt_d  = clk_filt_q;
        if (clk_hist_q == 4'hF) begin
            clk_filt_d = 1'b1;
        end else if (clk_hist_q == 4'h0) begin
            clk_filt_d = 1'b0;
        end
        fall      = clk_filt_q & ~clk_filt_d;
        ps2_bit   = data_sync_q[1];
        timed_out = (to_cnt_q == TIMEOUT);
        to_cnt_d  = fall ? 16'd0 : (timed_out ? to_cnt_q : to_cnt_q + 16'd1);
        // After reset the line may be mid-frame; wait for a quiet line before framing again
        resync_d  = resync_q & ~timed_out;

        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_ok_d  = parity_ok_q;
        byte_valid_d = 1'b0;
        if (state_q != RX_IDLE && timed_out) begin
            state_d = RX_IDLE;
        end else if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!resync_q && !ps2_bit) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {ps2_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    parity_ok_d = ^{shift_q, ps2_bit};
                    state_d     = RX_STOP;
                end
                default: begin
                    byte_valid_d = ps2_bit & parity_ok_q;
                    state_d      = RX_IDLE;
                end
            endcase
        end

        ext_d    = ext_q;
        rel_d    = rel_q;
        matrix_d = matrix_q;
        break_d  = break_q;
        if (byte_valid_q) begin
            if (shift_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PS2_REL) begin
                rel_d = 1'b1;
            end else begin
                if (map_loc.hit) begin
                    matrix_d[map_loc.row][map_loc.col] = ~rel_q;
                end
                if (shift_q == PS2_F12) begin
                    break_d = ~rel_q;
                end
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end

        // Probing the CPU column keeps the scan counter in step so autoscan resumes there
        if (!nKBEN) begin
            scan_col_d = col_sel;
        end else if (clk_en) begin
            scan_col_d = scan_col_q + 4'd1;
        end else begin
            scan_col_d = scan_col_q;
        end

        active_col    = nKBEN ? scan_col_q : col_sel;
        dip_off       = 3'(active_col - 4'd2);
        key_pressed_d = 1'b0;
        kb_irq_d      = 1'b0;
        if (active_col < 4'(KB_COLS)) begin
            if (row_sel == 3'd0 && active_col >= 4'd2) begin
                key_pressed_d = DIP_LINKS[dip_off];
            end else begin
                key_pressed_d = matrix_q[row_sel][active_col];
            end
            for (int r = 1; r < KB_ROWS; r++) begin
                kb_irq_d = kb_irq_d | matrix_q[r][active_col];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            clk_sync_q    <= 2'b11;
            data_sync_q   <= 2'b11;
            clk_hist_q    <= 4'hF;
            clk_filt_q    <= 1'b1;
            to_cnt_q      <= 16'd0;
            resync_q      <= 1'b1;
            state_q       <= RX_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            parity_ok_q   <= 1'b0;
            byte_valid_q  <= 1'b0;
            ext_q         <= 1'b0;
            rel_q         <= 1'b0;
            matrix_q      <= '0;
            break_q       <= 1'b0;
            scan_col_q    <= 4'd0;
            key_pressed_q <= 1'b0;
            kb_irq_q      <= 1'b0;
        end else begin
            clk_sync_q    <= clk_sync_d;
            data_sync_q   <= data_sync_d;
            clk_hist_q    <= clk_hist_d;
            clk_filt_q    <= clk_filt_d;
            to_cnt_q      <= to_cnt_d;
            resync_q      <= resync_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_ok_q   <= parity_ok_d;
            byte_valid_q  <= byte_valid_d;
            ext_q         <= ext_d;
            rel_q         <= rel_d;
            matrix_q      <= matrix_d;
            break_q       <= break_d;
            scan_col_q    <= scan_col_d;
            key_pressed_q <= key_pressed_d;
            kb_irq_q      <= kb_irq_d;
        end
    end

    assign key_pressed = key_pressed_q;
    assign kb_irq      = kb_irq_q;
    assign break_key   = break_q;

endmodule

// File: tb/tb_bbc_keyboard.sv
// tb/tb_bbc_keyboard.sv - self-checking bench for bbc_keyboard
module tb_bbc_keyboard;

    localparam logic [7:0]  DIP = 8'hA5;
    localparam logic [15:0] TO  = 16'd400;

    logic       clk = 1'b0;
    logic       nRESET = 1'b0;
    logic       clk_en = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nKBEN = 1'b0;
    logic [3:0] col_sel = 4'd0;
    logic [2:0] row_sel = 3'd0;
    logic       key_pressed, kb_irq, break_key;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        logic  kp;
        logic  irq;
    } exp_t;

    typedef struct {
        string      name;
        logic       kben;
        logic [3:0] col;
        logic [2:0] row;
        logic       kp;
        logic       irq;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    bbc_keyboard #(.DIP_LINKS(DIP), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .nRESET      (nRESET),
        .clk_en      (clk_en),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .nKBEN       (nKBEN),
        .col_sel     (col_sel),
        .row_sel     (row_sel),
        .key_pressed (key_pressed),
        .kb_irq      (kb_irq),
        .break_key   (break_key)
    );

    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic kben, input logic [3:0] col,
                                input logic [2:0] row, input logic kp, input logic irq);
        vec_t v;
        v.name = name; v.kben = kben; v.col = col; v.row = row; v.kp = kp; v.irq = irq;
        return v;
    endfunction

    task automatic score();
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".kp"}, key_pressed, e.kp);
        check({e.name, ".irq"}, kb_irq, e.irq);
    endtask

    task automatic probe(input vec_t v);
        exp_t e;
        nKBEN   = v.kben;
        col_sel = v.col;
        row_sel = v.row;
        e.name = v.name; e.kp = v.kp; e.irq = v.irq;
        sb.push_back(e);
        cyc(2);
        score();
    endtask

    task automatic run_tbl(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) probe(tbl[i]);
    endtask

    task automatic ps2_send_bit(input logic b);
        ps2_data = b;
        cyc(10);
        ps2_clk = 1'b0;
        cyc(25);
        ps2_clk = 1'b1;
        cyc(15);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        ps2_send_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_send_bit(b[i]);
        ps2_send_bit(~(^b) ^ bad_par);
        ps2_send_bit(1'b1);
        cyc(5);
    endtask

    // Expected PA7 with row 0 selected and only SHIFT held
    function automatic logic row0_model(input int col);
        logic [7:0] d;
        d = DIP;
        if (col == 0) return 1'b1;
        if (col >= 2 && col <= 9) return d[col-2];
        return 1'b0;
    endfunction

    initial begin
        int scan;
        logic [7:0] dip_v;
        dip_v = DIP;

        tbl.push_back(mk("a_on",       0, 4'd1,  3'd4, 1, 1));   // 0
        tbl.push_back(mk("a_row3",     0, 4'd1,  3'd3, 0, 1));   // 1
        tbl.push_back(mk("c0_row4",    0, 4'd0,  3'd4, 0, 0));   // 2
        tbl.push_back(mk("a_off",      0, 4'd1,  3'd4, 0, 0));   // 3
        tbl.push_back(mk("par_bad",    0, 4'd1,  3'd4, 0, 0));   // 4
        tbl.push_back(mk("par_good",   0, 4'd1,  3'd4, 1, 1));   // 5
        for (int c = 2; c <= 9; c++)                             // 6..13
            tbl.push_back(mk($sformatf("dip_c%0d", c), 0, 4'(c), 3'd0, dip_v[c-2], 0));
        tbl.push_back(mk("dip_c12",    0, 4'd12, 3'd0, 0, 0));   // 14
        tbl.push_back(mk("c12_row4",   0, 4'd12, 3'd4, 0, 0));   // 15
        tbl.push_back(mk("shift_on",   0, 4'd0,  3'd0, 1, 0));   // 16
        tbl.push_back(mk("up_on",      0, 4'd9,  3'd3, 1, 1));   // 17
        tbl.push_back(mk("up_off",     0, 4'd9,  3'd3, 0, 0));   // 18
        tbl.push_back(mk("kp8_plain",  0, 4'd9,  3'd3, 0, 0));   // 19
        tbl.push_back(mk("a_after_to", 0, 4'd1,  3'd4, 1, 1));   // 20
        tbl.push_back(mk("in_reset",   0, 4'd1,  3'd4, 0, 0));   // 21
        tbl.push_back(mk("a_post_rst", 0, 4'd1,  3'd4, 1, 1));   // 22

        nRESET = 1'b0;
        cyc(4);
        check("rst.kp", key_pressed, 1'b0);
        check("rst.irq", kb_irq, 1'b0);
        check("rst.brk", break_key, 1'b0);
        nRESET = 1'b1;
        cyc(int'(TO) + 20);

        send_byte(8'h1C, 1'b0);
        run_tbl(0, 2);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        run_tbl(3, 3);
        send_byte(8'h1C, 1'b1);
        run_tbl(4, 4);
        send_byte(8'h1C, 1'b0);
        run_tbl(5, 5);

        // Autoscan with A (row 4, column 1) held
        col_sel = 4'd0; row_sel = 3'd4; nKBEN = 1'b0;
        cyc(2);
        nKBEN = 1'b1;
        scan = 0;
        for (int i = 0; i < 32; i++) begin
            clk_en = 1'b1;
            cyc(1);
            clk_en = 1'b0;
            scan = (scan + 1) % 16;
            cyc(2);
            check($sformatf("scanA%0d.irq", i), kb_irq, scan == 1);
            check($sformatf("scanA%0d.kp", i), key_pressed, scan == 1);
        end

        run_tbl(6, 15);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);

        // SHIFT alone: row 0 never raises the interrupt
        send_byte(8'h12, 1'b0);
        run_tbl(16, 16);
        col_sel = 4'd0; row_sel = 3'd0; nKBEN = 1'b0;
        cyc(2);
        nKBEN = 1'b1;
        scan = 0;
        for (int i = 0; i < 16; i++) begin
            clk_en = 1'b1;
            cyc(1);
            clk_en = 1'b0;
            scan = (scan + 1) % 16;
            cyc(2);
            check($sformatf("scanS%0d.irq", i), kb_irq, 1'b0);
            check($sformatf("scanS%0d.kp", i), key_pressed, row0_model(scan));
        end
        nKBEN = 1'b0;
        send_byte(8'hF0, 1'b0);
        send_byte(8'h12, 1'b0);

        send_byte(8'h07, 1'b0);
        check("f12_make", break_key, 1'b1);
        run_tbl(3, 3);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h07, 1'b0);
        check("f12_break", break_key, 1'b0);

        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        run_tbl(17, 17);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        run_tbl(18, 18);
        send_byte(8'h75, 1'b0);
        run_tbl(19, 19);

        // Stalled partial frame must be abandoned
        ps2_send_bit(1'b0);
        ps2_send_bit(1'b1);
        ps2_send_bit(1'b0);
        ps2_send_bit(1'b1);
        ps2_send_bit(1'b1);
        cyc(int'(TO) + 10);
        send_byte(8'h1C, 1'b0);
        run_tbl(20, 20);

        // Reset in the middle of a frame, then the tail of that frame arrives
        send_byte(8'h07, 1'b0);
        check("brk_before_rst", break_key, 1'b1);
        ps2_send_bit(1'b0);
        ps2_send_bit(1'b0);
        ps2_send_bit(1'b1);
        ps2_send_bit(1'b1);
        ps2_send_bit(1'b0);
        nRESET = 1'b0;
        run_tbl(21, 21);
        check("rst_mid.brk", break_key, 1'b0);
        nRESET = 1'b1;
        ps2_send_bit(1'b0);
        ps2_send_bit(1'b0);
        ps2_send_bit(1'b0);
        ps2_send_bit(1'b0);
        ps2_send_bit(1'b1);
        ps2_send_bit(1'b1);
        run_tbl(21, 21);
        check("rst_tail.brk", break_key, 1'b0);
        cyc(int'(TO) + 20);
        send_byte(8'h1C, 1'b0);
        run_tbl(22, 22);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
